// File: rtl/secure_config_ctrl.sv
// secure_config_ctrl: password-gated configuration commit with lockout.
// Ports: clk, arst (async active-low), request/confirm/password/syskey/configin in;
//   configout, write_en, fail_cnt, locked (registered), dbg_state out.
module secure_config_ctrl #(
  parameter int CFG_W       = 35,
  parameter int KEY_W       = 2,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT     = 8,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           arst,
  input  logic                           request,
  input  logic                           confirm,
  input  logic [KEY_W-1:0]               password,
  input  logic [KEY_W-1:0]               syskey,
  input  logic [CFG_W-1:0]               configin,
  output logic [CFG_W-1:0]               configout,
  output logic                           write_en,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output logic                           locked,
  output logic [2:0]                     dbg_state
);

  localparam int FW = $clog2(MAX_TRIES+1);
  localparam int TW = $clog2(TIMEOUT+1);
  localparam int LW = $clog2(LOCK_CYCLES+1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    AUTH   = 3'd1,
    GRANT  = 3'd2,
    DENY   = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [TW-1:0]    tcnt, tcnt_d;
  logic [LW-1:0]    lcnt, lcnt_d;
  logic [FW-1:0]    fail_d;
  logic [CFG_W-1:0] cfg_d;
  logic             write_en_d;
  logic             locked_d;

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state     <= IDLE;
      tcnt      <= '0;
      lcnt      <= '0;
      fail_cnt  <= '0;
      configout <= '0;
      write_en  <= 1'b0;
      locked    <= 1'b0;
    end else begin
      state     <= state_d;
      tcnt      <= tcnt_d;
      lcnt      <= lcnt_d;
      fail_cnt  <= fail_d;
      configout <= cfg_d;
      write_en  <= write_en_d;
      locked    <= locked_d;
    end
  end

  always_comb begin
    state_d = state;
    tcnt_d  = tcnt;
    lcnt_d  = lcnt;
    fail_d  = fail_cnt;
    cfg_d   = configout;
    case (state)
      IDLE: begin
        if (request) begin
          state_d = AUTH;
          tcnt_d  = '0;
        end
      end
      AUTH: begin
        // confirm takes priority over an expiring timeout
        if (confirm) begin
          if (password == syskey) begin
            state_d = GRANT;
            cfg_d   = configin;
            fail_d  = '0;
          end else begin
            state_d = DENY;
            if (fail_cnt != FW'(MAX_TRIES))
              fail_d = fail_cnt + FW'(1);
          end
        end else if (tcnt == TW'(TIMEOUT-1)) begin
          state_d = IDLE;
          tcnt_d  = '0;
        end else begin
          tcnt_d = tcnt + TW'(1);
        end
      end
      GRANT: state_d = IDLE;
      DENY: begin
        if (fail_cnt == FW'(MAX_TRIES)) begin
          state_d = LOCKED;
          lcnt_d  = '0;
        end else begin
          state_d = IDLE;
        end
      end
      LOCKED: begin
        if (lcnt == LW'(LOCK_CYCLES-1)) begin
          state_d = IDLE;
          lcnt_d  = '0;
          fail_d  = '0;
        end else begin
          lcnt_d = lcnt + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // outputs decoded from next state so the flops track the state exactly
  always_comb begin
    write_en_d = (state_d == GRANT);
    locked_d   = (state_d == LOCKED);
    dbg_state  = state;
  end

endmodule

// File: tb/tb_secure_config_ctrl.sv
// tb_secure_config_ctrl: directed checks of secure_config_ctrl.
// Default instance plus a small-parameter instance for the lockout sweep.
module tb_secure_config_ctrl;

  logic        clk;
  logic        arst;
  logic        request, confirm;
  logic [1:0]  password, syskey;
  logic [34:0] configin;
  logic [34:0] configout;
  logic        write_en;
  logic [1:0]  fail_cnt;
  logic        locked;
  logic [2:0]  dbg_state;

  logic        s_request, s_confirm;
  logic [3:0]  s_password, s_syskey;
  logic [7:0]  s_configin, s_configout;
  logic        s_write_en;
  logic [0:0]  s_fail_cnt;
  logic        s_locked;
  logic [2:0]  s_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  secure_config_ctrl dut (
    .clk(clk), .arst(arst), .request(request), .confirm(confirm),
    .password(password), .syskey(syskey), .configin(configin),
    .configout(configout), .write_en(write_en), .fail_cnt(fail_cnt),
    .locked(locked), .dbg_state(dbg_state)
  );

  secure_config_ctrl #(
    .CFG_W(8), .KEY_W(4), .MAX_TRIES(1), .TIMEOUT(8), .LOCK_CYCLES(1)
  ) sdut (
    .clk(clk), .arst(arst), .request(s_request), .confirm(s_confirm),
    .password(s_password), .syskey(s_syskey), .configin(s_configin),
    .configout(s_configout), .write_en(s_write_en), .fail_cnt(s_fail_cnt),
    .locked(s_locked), .dbg_state(s_dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".state"}, 64'(dbg_state), 64'd0);
    chk({tag, ".cfg"}, 64'(configout), 64'd0);
    chk({tag, ".we"}, 64'(write_en), 64'd0);
    chk({tag, ".fail"}, 64'(fail_cnt), 64'd0);
    chk({tag, ".locked"}, 64'(locked), 64'd0);
  endtask

  initial begin
    arst = 1'b0;
    request = 0; confirm = 0; password = 0; syskey = 2'b10; configin = 0;
    s_request = 0; s_confirm = 0; s_password = 0; s_syskey = 4'hA;
    s_configin = 0;
    #12;
    chk_all_zero("reset");
    arst = 1'b1;
    #1;
    chk("reset_rel.state", 64'(dbg_state), 64'd0);

    // grant
    step();
    request = 1;
    step();
    chk("grant.auth", 64'(dbg_state), 64'd1);
    request = 0; confirm = 1; password = 2'b10; configin = 35'h1_2345_6789;
    step();
    chk("grant.state", 64'(dbg_state), 64'd2);
    chk("grant.we", 64'(write_en), 64'd1);
    chk("grant.cfg", 64'(configout), 64'h1_2345_6789);
    chk("grant.fail", 64'(fail_cnt), 64'd0);
    confirm = 0; configin = 35'h7_FFFF_0000;
    step();
    chk("grant.idle", 64'(dbg_state), 64'd0);
    chk("grant.we_off", 64'(write_en), 64'd0);

    // lockout: three bad sessions
    password = 2'b01;
    for (int k = 1; k <= 3; k++) begin
      request = 1;
      step();
      chk("lock.auth", 64'(dbg_state), 64'd1);
      request = 0; confirm = 1;
      step();
      chk("lock.deny", 64'(dbg_state), 64'd3);
      chk("lock.fail", 64'(fail_cnt), 64'(k));
      chk("lock.we", 64'(write_en), 64'd0);
      confirm = 0;
      step();
      if (k < 3) begin
        chk("lock.idle", 64'(dbg_state), 64'd0);
      end else begin
        chk("lock.locked_st", 64'(dbg_state), 64'd4);
      end
    end
    chk("lock.locked", 64'(locked), 64'd1);
    request = 1; confirm = 1; password = 2'b10;
    for (int i = 1; i < 16; i++) begin
      step();
      chk("lock.hold", 64'(locked), 64'd1);
      chk("lock.hold_st", 64'(dbg_state), 64'd4);
    end
    step();
    request = 0; confirm = 0; password = 2'b01;
    chk("lock.exit_st", 64'(dbg_state), 64'd0);
    chk("lock.exit_lk", 64'(locked), 64'd0);
    chk("lock.exit_fail", 64'(fail_cnt), 64'd0);
    chk("lock.cfg_kept", 64'(configout), 64'h1_2345_6789);

    // recovery: two failures, timeout keeps fail_cnt, late confirm grants
    for (int k = 1; k <= 2; k++) begin
      request = 1;
      step();
      request = 0; confirm = 1;
      step();
      chk("rec.fail", 64'(fail_cnt), 64'(k));
      confirm = 0;
      step();
      chk("rec.idle", 64'(dbg_state), 64'd0);
    end
    request = 1;
    step();
    request = 0;
    for (int i = 1; i < 8; i++) begin
      step();
      chk("tmo.auth", 64'(dbg_state), 64'd1);
      chk("tmo.we", 64'(write_en), 64'd0);
    end
    step();
    chk("tmo.idle", 64'(dbg_state), 64'd0);
    chk("tmo.fail", 64'(fail_cnt), 64'd2);
    chk("tmo.cfg", 64'(configout), 64'h1_2345_6789);
    request = 1;
    step();
    request = 0;
    for (int i = 1; i < 8; i++) step();
    chk("tmo2.auth", 64'(dbg_state), 64'd1);
    confirm = 1; password = 2'b10; configin = 35'h4_0A0A_5555;
    step();
    chk("tmo2.grant", 64'(dbg_state), 64'd2);
    chk("tmo2.we", 64'(write_en), 64'd1);
    chk("tmo2.fail", 64'(fail_cnt), 64'd0);
    chk("tmo2.cfg", 64'(configout), 64'h4_0A0A_5555);
    confirm = 0;
    step();
    chk("tmo2.we_once", 64'(write_en), 64'd0);
    chk("tmo2.idle", 64'(dbg_state), 64'd0);

    // one failure then reset mid-AUTH
    password = 2'b01;
    request = 1;
    step();
    request = 0; confirm = 1;
    step();
    confirm = 0;
    step();
    request = 1;
    step();
    chk("rst.auth", 64'(dbg_state), 64'd1);
    chk("rst.fail_pre", 64'(fail_cnt), 64'd1);
    request = 0; confirm = 1; password = 2'b10;
    #2;
    arst = 1'b0;
    #1;
    chk_all_zero("rst.async");
    #3;
    arst = 1'b1;
    #1;
    chk("rst.rel", 64'(dbg_state), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst.no_we", 64'(write_en), 64'd0);
      chk("rst.idle", 64'(dbg_state), 64'd0);
    end
    confirm = 0;

    // small-parameter instance: one failure locks for one cycle
    s_request = 1;
    step();
    chk("sw.auth", 64'(s_dbg_state), 64'd1);
    s_request = 0; s_confirm = 1; s_password = 4'hA; s_configin = 8'hC3;
    step();
    chk("sw.grant_we", 64'(s_write_en), 64'd1);
    chk("sw.grant_cfg", 64'(s_configout), 64'hC3);
    s_confirm = 0;
    step();
    s_request = 1;
    step();
    s_request = 0; s_confirm = 1; s_password = 4'h5;
    step();
    chk("sw.deny", 64'(s_dbg_state), 64'd3);
    chk("sw.fail", 64'(s_fail_cnt), 64'd1);
    s_confirm = 0;
    step();
    chk("sw.locked", 64'(s_locked), 64'd1);
    chk("sw.locked_st", 64'(s_dbg_state), 64'd4);
    step();
    chk("sw.unlock", 64'(s_locked), 64'd0);
    chk("sw.idle", 64'(s_dbg_state), 64'd0);
    chk("sw.fail_clr", 64'(s_fail_cnt), 64'd0);
    chk("sw.cfg_kept", 64'(s_configout), 64'hC3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
